// File: rtl/iob_clint_pkg.sv
// iob_clint_pkg: shared constants and helpers for the iob_clint CLINT.
//   - Byte address constants of the standard CLINT register map
//   - Per-hart strides and low/high word offsets for the 64-bit registers
//   - Reset value of mtimecmp (all ones, so no timer interrupt is pending
//     out of reset)
//   - merge_bytes: applies the byte enables of a write to a 32-bit word
package iob_clint_pkg;

    localparam logic [15:0] MSIP_BASE       = 16'h0000;
    localparam logic [15:0] MTIMECMP_BASE   = 16'h4000;
    localparam logic [15:0] MTIME_BASE      = 16'hBFF8;

    localparam logic [15:0] MSIP_STRIDE     = 16'd4;
    localparam logic [15:0] MTIMECMP_STRIDE = 16'd8;
    localparam logic [15:0] WORD_LO_OFF     = 16'd0;
    localparam logic [15:0] WORD_HI_OFF     = 16'd4;

    localparam logic [63:0] MTIMECMP_RST    = 64'hFFFF_FFFF_FFFF_FFFF;

    // Byte-lane merge: every lane whose strobe is set takes the new data,
    // every other lane keeps the old register contents.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  strb);
        logic [31:0] result;
        result = old_word;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) begin
                result[8*b +: 8] = new_word[8*b +: 8];
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/iob_clint_rtc_tick.sv
// iob_clint_rtc_tick: turns the slow rtc input into a one-cycle tick pulse
// in the clk_i domain, one pulse per rtc rising edge.
//
// Configuration macro: IOB_CLINT_RTC_SYNC_EN
//   defined     : rtc goes through a 2-flop synchronizer before the edge
//                 detector (mtime moves 3 clk_i edges after the rtc edge)
//   not defined : rtc is assumed synchronous to clk_i and is edge-detected
//                 directly (mtime moves 1 clk_i edge after the rtc edge)
//
// Ports:
//   clk_i  in  : system clock
//   arst_i in  : synchronous active-high reset
//   rtc_i  in  : real-time clock input
//   tick_o out : one-cycle pulse per detected rtc rising edge
module iob_clint_rtc_tick (
    input  logic clk_i,
    input  logic arst_i,
    input  logic rtc_i,
    output logic tick_o
);

`ifdef IOB_CLINT_RTC_SYNC_EN

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic prev_q,  prev_d;

    // Two synchronizer stages followed by the previous-value flop that the
    // edge detector compares against.
    always_comb begin
        sync1_d = rtc_i;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
        tick_o  = sync2_q & ~prev_q;
    end

    // All stages clear to 0 so a high rtc right after reset still produces
    // exactly one tick once it has crossed the synchronizer.
    always_ff @(posedge clk_i) begin
        if (arst_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
        end
    end

`else

    logic prev_q, prev_d;

    // rtc already lives in the clk_i domain, so the edge is detected on
    // the raw input and the tick is seen at the very next edge.
    always_comb begin
        prev_d = rtc_i;
        tick_o = rtc_i & ~prev_q;
    end

    always_ff @(posedge clk_i) begin
        if (arst_i) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= prev_d;
        end
    end

`endif

endmodule

// File: rtl/iob_clint.sv
// iob_clint: RISC-V Core-Local Interruptor on the IOb native bus.
//   mtime       : 64-bit counter, +1 per rtc rising edge, wraps to 0
//   mtimecmp[i] : per-hart compare, mtip[i] = (mtime >= mtimecmp[i])
//   msip[i]     : per-hart software interrupt bit
//
// Configuration macro: IOB_CLINT_RTC_SYNC_EN (see iob_clint_rtc_tick)
//
// Parameters: ADDR_W (byte address width), DATA_W (must be 32),
//             N_CORES (1..16)
// Ports:
//   clk_i, arst_i        : clock, synchronous active-high reset
//   rtc                  : real-time clock input
//   iob_avalid/addr/wdata/wstrb : request (wstrb != 0 means write)
//   iob_ready            : request accepted (1 outside reset)
//   iob_rvalid/iob_rdata : registered read response, one cycle later
//   mtip, msip           : per-hart interrupt outputs
module iob_clint
    import iob_clint_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 32,
    parameter int N_CORES = 1
) (
    input  logic                  clk_i,
    input  logic                  arst_i,
    input  logic                  rtc,
    input  logic                  iob_avalid,
    input  logic [ADDR_W-1:0]     iob_addr,
    input  logic [DATA_W-1:0]     iob_wdata,
    input  logic [DATA_W/8-1:0]   iob_wstrb,
    output logic                  iob_rvalid,
    output logic [DATA_W-1:0]     iob_rdata,
    output logic                  iob_ready,
    output logic [N_CORES-1:0]    mtip,
    output logic [N_CORES-1:0]    msip
);

    logic                     tick;
    logic                     write_en;
    logic                     read_en;
    logic [DATA_W-1:0]        read_word;

    logic [63:0]              mtime_q,    mtime_d;
    logic [N_CORES-1:0][63:0] mtimecmp_q, mtimecmp_d;
    logic [N_CORES-1:0]       msip_q,     msip_d;
    logic                     rvalid_q,   rvalid_d;
    logic [DATA_W-1:0]        rdata_q,    rdata_d;

    iob_clint_rtc_tick u_rtc_tick (
        .clk_i  (clk_i),
        .arst_i (arst_i),
        .rtc_i  (rtc),
        .tick_o (tick)
    );

    assign write_en   = iob_avalid & (|iob_wstrb);
    assign read_en    = iob_avalid & ~(|iob_wstrb);
    assign iob_ready  = ~arst_i;
    assign iob_rvalid = rvalid_q;
    assign iob_rdata  = rdata_q;
    assign msip       = msip_q;

    // Address decode, register updates and read mux. The mtime increment
    // is the default; a bus write to either mtime word overrides it and
    // the other word is left untouched (no carry from the tick).
    always_comb begin
        mtime_d    = mtime_q + {63'd0, tick};
        mtimecmp_d = mtimecmp_q;
        msip_d     = msip_q;
        read_word  = '0;
        rvalid_d   = 1'b0;
        rdata_d    = rdata_q;

        if (iob_addr == ADDR_W'(32'(MTIME_BASE) + 32'(WORD_LO_OFF))) begin
            read_word = mtime_q[31:0];
            if (write_en) begin
                mtime_d = {mtime_q[63:32],
                           merge_bytes(mtime_q[31:0], iob_wdata, iob_wstrb)};
            end
        end

        if (iob_addr == ADDR_W'(32'(MTIME_BASE) + 32'(WORD_HI_OFF))) begin
            read_word = mtime_q[63:32];
            if (write_en) begin
                mtime_d = {merge_bytes(mtime_q[63:32], iob_wdata, iob_wstrb),
                           mtime_q[31:0]};
            end
        end

        for (int i = 0; i < N_CORES; i++) begin
            // Only bit 0 of msip is implemented, so only lane 0 matters.
            if (iob_addr == ADDR_W'(32'(MSIP_BASE) + 32'(MSIP_STRIDE) * i)) begin
                read_word = {{(DATA_W-1){1'b0}}, msip_q[i]};
                if (write_en && iob_wstrb[0]) begin
                    msip_d[i] = iob_wdata[0];
                end
            end

            if (iob_addr == ADDR_W'(32'(MTIMECMP_BASE) + 32'(MTIMECMP_STRIDE) * i
                                    + 32'(WORD_LO_OFF))) begin
                read_word = mtimecmp_q[i][31:0];
                if (write_en) begin
                    mtimecmp_d[i][31:0] = merge_bytes(mtimecmp_q[i][31:0],
                                                      iob_wdata, iob_wstrb);
                end
            end

            if (iob_addr == ADDR_W'(32'(MTIMECMP_BASE) + 32'(MTIMECMP_STRIDE) * i
                                    + 32'(WORD_HI_OFF))) begin
                read_word = mtimecmp_q[i][63:32];
                if (write_en) begin
                    mtimecmp_d[i][63:32] = merge_bytes(mtimecmp_q[i][63:32],
                                                       iob_wdata, iob_wstrb);
                end
            end
        end

        // Unmapped reads fall through with read_word = 0.
        if (read_en) begin
            rvalid_d = 1'b1;
            rdata_d  = read_word;
        end
    end

    // Timer interrupts compare straight from register state, so a write to
    // mtime or mtimecmp shows up on mtip in the cycle after the write edge.
    always_comb begin
        mtip = '0;
        for (int i = 0; i < N_CORES; i++) begin
            mtip[i] = (mtime_q >= mtimecmp_q[i]);
        end
    end

    // Register state. Reset also cancels a read response that was due in
    // the next cycle.
    always_ff @(posedge clk_i) begin
        if (arst_i) begin
            mtime_q    <= '0;
            mtimecmp_q <= {N_CORES{MTIMECMP_RST}};
            msip_q     <= '0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
        end else begin
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            msip_q     <= msip_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
        end
    end

endmodule

// File: tb/tb_iob_clint.sv
// tb_iob_clint: directed self-checking bench for iob_clint (N_CORES = 1).
// Works with or without IOB_CLINT_RTC_SYNC_EN: every rtc pulse is held
// long enough for either tick latency to have completed before checking.
module tb_iob_clint;

    logic        clk;
    logic        arst_i;
    logic        rtc;
    logic        iob_avalid;
    logic [15:0] iob_addr;
    logic [31:0] iob_wdata;
    logic [3:0]  iob_wstrb;
    logic        iob_rvalid;
    logic [31:0] iob_rdata;
    logic        iob_ready;
    logic [0:0]  mtip;
    logic [0:0]  msip;

    int check_count = 0;
    int error_count = 0;

    iob_clint #(
        .ADDR_W  (16),
        .DATA_W  (32),
        .N_CORES (1)
    ) dut (
        .clk_i      (clk),
        .arst_i     (arst_i),
        .rtc        (rtc),
        .iob_avalid (iob_avalid),
        .iob_addr   (iob_addr),
        .iob_wdata  (iob_wdata),
        .iob_wstrb  (iob_wstrb),
        .iob_rvalid (iob_rvalid),
        .iob_rdata  (iob_rdata),
        .iob_ready  (iob_ready),
        .mtip       (mtip),
        .msip       (msip)
    );

    // 100 MHz system clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check, reports any mismatch.
    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        check_count++;
        if (actual !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    // One bus write; the bench drives on falling edges so the DUT samples
    // stable inputs on the rising edge.
    task automatic applyStimulus(input logic [15:0] addr, input logic [31:0] data,
                                 input logic [3:0] strb);
        @(negedge clk);
        iob_avalid = 1'b1;
        iob_addr   = addr;
        iob_wdata  = data;
        iob_wstrb  = strb;
        @(negedge clk);
        iob_avalid = 1'b0;
        iob_wstrb  = 4'h0;
        checkOutput("write_no_rvalid", {63'd0, iob_rvalid}, 64'd0);
    endtask

    // One bus read: ready in the request cycle, rvalid exactly one cycle
    // later and only for that cycle.
    task automatic readCheck(input string tag, input logic [15:0] addr,
                             input logic [31:0] expected);
        @(negedge clk);
        iob_avalid = 1'b1;
        iob_addr   = addr;
        iob_wstrb  = 4'h0;
        checkOutput("read_ready", {63'd0, iob_ready}, 64'd1);
        checkOutput("read_rvalid_early", {63'd0, iob_rvalid}, 64'd0);
        @(negedge clk);
        iob_avalid = 1'b0;
        checkOutput("read_rvalid", {63'd0, iob_rvalid}, 64'd1);
        checkOutput(tag, {32'd0, iob_rdata}, {32'd0, expected});
        @(negedge clk);
        checkOutput("read_rvalid_drop", {63'd0, iob_rvalid}, 64'd0);
    endtask

    // One full rtc period: 3 cycles high, 3 cycles low.
    task automatic rtcTick();
        @(negedge clk);
        rtc = 1'b1;
        repeat (3) @(negedge clk);
        rtc = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        arst_i     = 1'b1;
        rtc        = 1'b0;
        iob_avalid = 1'b0;
        iob_addr   = 16'h0;
        iob_wdata  = 32'h0;
        iob_wstrb  = 4'h0;

        $display("[TB] reset");
        repeat (100) @(negedge clk);
        checkOutput("ready_in_reset", {63'd0, iob_ready}, 64'd0);
        arst_i = 1'b0;
        @(negedge clk);
        checkOutput("reset_mtip",   {63'd0, mtip},       64'd0);
        checkOutput("reset_msip",   {63'd0, msip},       64'd0);
        checkOutput("reset_rvalid", {63'd0, iob_rvalid}, 64'd0);
        checkOutput("reset_rdata",  {32'd0, iob_rdata},  64'd0);
        checkOutput("reset_ready",  {63'd0, iob_ready},  64'd1);
        readCheck("reset_cmp_lo",   16'h4000, 32'hFFFF_FFFF);
        readCheck("reset_cmp_hi",   16'h4004, 32'hFFFF_FFFF);
        readCheck("reset_mtime_lo", 16'hBFF8, 32'h0);

        $display("[TB] timer interrupt");
        applyStimulus(16'h4000, 32'd200, 4'hF);
        applyStimulus(16'h4004, 32'd0,   4'hF);
        checkOutput("mtip_armed", {63'd0, mtip}, 64'd0);
        for (int k = 0; k < 199; k++) rtcTick();
        checkOutput("mtip_at_199", {63'd0, mtip}, 64'd0);
        readCheck("mtime_199", 16'hBFF8, 32'd199);
        rtcTick();
        checkOutput("mtip_at_200", {63'd0, mtip}, 64'd1);
        readCheck("mtime_200_lo", 16'hBFF8, 32'd200);
        readCheck("mtime_200_hi", 16'hBFFC, 32'd0);

        $display("[TB] rearm");
        applyStimulus(16'hBFF8, 32'd0, 4'hF);
        checkOutput("mtip_rearm", {63'd0, mtip}, 64'd0);
        for (int k = 0; k < 3; k++) rtcTick();
        readCheck("mtime_restart_lo", 16'hBFF8, 32'd3);
        readCheck("mtime_restart_hi", 16'hBFFC, 32'd0);

        $display("[TB] software interrupt");
        applyStimulus(16'h0000, 32'd1, 4'hF);
        checkOutput("msip_set", {63'd0, msip}, 64'd1);
        readCheck("msip_read_1", 16'h0000, 32'd1);
        applyStimulus(16'h0000, 32'hFFFF_FFFE, 4'hF);
        checkOutput("msip_bit0_clear", {63'd0, msip}, 64'd0);
        applyStimulus(16'h0000, 32'hFFFF_FFFF, 4'hF);
        readCheck("msip_upper_zero", 16'h0000, 32'd1);
        applyStimulus(16'h0000, 32'd0, 4'h2);
        checkOutput("msip_lane0_off", {63'd0, msip}, 64'd1);
        applyStimulus(16'h0000, 32'd0, 4'hF);
        checkOutput("msip_clear", {63'd0, msip}, 64'd0);

        $display("[TB] byte strobes");
        applyStimulus(16'h4000, 32'hFFFF_FFFF, 4'hF);
        applyStimulus(16'h4000, 32'hAABB_CCDD, 4'h2);
        readCheck("cmp_strb_2", 16'h4000, 32'hFFFF_CCFF);
        applyStimulus(16'h4000, 32'h1122_3344, 4'h9);
        readCheck("cmp_strb_9", 16'h4000, 32'h11FF_CC44);
        checkOutput("mtip_below_cmp", {63'd0, mtip}, 64'd0);

        $display("[TB] mtime wrap");
        applyStimulus(16'hBFF8, 32'hFFFF_FFFF, 4'hF);
        applyStimulus(16'hBFFC, 32'hFFFF_FFFF, 4'hF);
        checkOutput("mtip_at_max", {63'd0, mtip}, 64'd1);
        rtcTick();
        readCheck("wrap_lo", 16'hBFF8, 32'd0);
        readCheck("wrap_hi", 16'hBFFC, 32'd0);
        checkOutput("mtip_after_wrap", {63'd0, mtip}, 64'd0);

        $display("[TB] unmapped addresses");
        applyStimulus(16'h1000, 32'h0000_1234, 4'hF);
        readCheck("unmapped_1000", 16'h1000, 32'd0);
        readCheck("unmapped_4008", 16'h4008, 32'd0);
        readCheck("unmapped_bff4", 16'hBFF4, 32'd0);

        $display("[TB] reset during read");
        @(negedge clk);
        iob_avalid = 1'b1;
        iob_addr   = 16'h4004;
        iob_wstrb  = 4'h0;
        arst_i     = 1'b1;
        @(negedge clk);
        iob_avalid = 1'b0;
        checkOutput("rst_cancel_rvalid", {63'd0, iob_rvalid}, 64'd0);
        checkOutput("rst_cancel_rdata",  {32'd0, iob_rdata},  64'd0);
        checkOutput("rst_ready_low",     {63'd0, iob_ready},  64'd0);
        @(negedge clk);
        arst_i = 1'b0;
        @(negedge clk);
        readCheck("rst_cmp_lo_restored", 16'h4000, 32'hFFFF_FFFF);
        readCheck("rst_mtime_cleared",   16'hBFFC, 32'd0);

        $display("CHECKS %0d ERRORS %0d", check_count, error_count);
        $finish;
    end

endmodule
